hazard_ctrl: RTL and testbench

//  Pipeline stall controller for the 5-stage MIPS core. Drives IF_en (PC write enable of the fetch stage),
//  D_en (IF/ID register enable) and E_clr (ID/EX bubble insert). Stalls on Tuse/Tnew data hazards against
//  E and M, and on HI/LO access while the multiply/divide unit is busy; owns the mult/div busy sequencer.

---
 rtl/mips_hazard_pkg.sv | 53 +++++
 rtl/md_busy_timer.sv | 77 +++++++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_hazard_pkg
//  Description : Shared encodings, defaults and the per-operand Tuse/Tnew
//                hazard predicate for the 5-stage MIPS stall controller.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_hazard_pkg;

  // Tuse encodings: cycles until the D-stage instruction needs the operand.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;   // operand not read at all

  // Tnew encodings: cycles until the producer's result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Mult/div busy window defaults (cycles after the start leaves E).
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Busy sequencer states.
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // One source operand against the producers in E and M. $0 is hard-wired
  // zero and an unused operand cannot be hazarded; either producer alone is
  // enough to stall.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic       we_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic       we_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = we_e && (a3_e == src) && (tnew_e > tuse);
    hit_m = we_m && (a3_m == src) && (tnew_m > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : IDLE/BUSY sequencer tracking how long the multiply/divide
//                unit stays busy after a start leaves the E stage.
//  Revision    : 1.0  initial release
// ============================================================================
module md_busy_timer
  import mips_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_div_E,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_load;

  assign w_load = md_div_E ? C_DIV_LOAD : C_MULT_LOAD;

  // State and counter registers; reset aborts any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on a start, count down while busy, drop to idle at 1.
  // A start while already busy (blocked by the stall logic in a legal
  // program) simply restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start_E) begin
          cnt_d   = w_load;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_start_E) begin
          cnt_d   = w_load;
          state_d = MD_BUSY;
        end else if (cnt_q == C_CNT_ONE) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d   = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall controller for the 5-stage MIPS pipeline. Freezes
//                fetch/decode and bubbles ID/EX on Tuse/Tnew data hazards and
//                on HI/LO access while the mult/div unit is busy.
//                Optional macro HAZARD_STALL_CNT_EN adds a 32-bit stall_cycles
//                performance counter port.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  Tnew_M,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  output logic        IF_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_busy    (md_busy)
  );

  assign w_stall_rs = src_hazard(rs_D, Tuse_rs_D, A3_E, RegWrite_E, Tnew_E,
                                 A3_M, RegWrite_M, Tnew_M);
  assign w_stall_rt = src_hazard(rt_D, Tuse_rt_D, A3_E, RegWrite_E, Tnew_E,
                                 A3_M, RegWrite_M, Tnew_M);

  // A start still in E counts as busy so the HI/LO user right behind it waits.
  assign w_stall_md = md_use_D && (md_busy || md_start_E);

  // Combined stall; the reset cycle always lets the pipeline advance.
  always_comb begin
    w_stall = 1'b0;
    if (!reset) begin
      w_stall = w_stall_rs || w_stall_rt || w_stall_md;
    end
  end

  assign IF_en = ~w_stall;
  assign D_en  = ~w_stall;
  assign E_clr = w_stall;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running stall counter; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Each cycle's expected
//                {IF_en, D_en, E_clr, md_busy} is queued as stimulus is
//                applied and popped when the outputs settle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, A3_E, A3_M;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic        RegWrite_E, RegWrite_M;
  logic        md_use_D, md_start_E, md_div_E;
  logic        IF_en, D_en, E_clr, md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .Tuse_rs_D  (Tuse_rs_D),
    .Tuse_rt_D  (Tuse_rt_D),
    .A3_E       (A3_E),
    .RegWrite_E (RegWrite_E),
    .Tnew_E     (Tnew_E),
    .A3_M       (A3_M),
    .RegWrite_M (RegWrite_M),
    .Tnew_M     (Tnew_M),
    .md_use_D   (md_use_D),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .IF_en      (IF_en),
    .D_en       (D_en),
    .E_clr      (E_clr),
    .md_busy    (md_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Apply one cycle of pipeline inputs (stimulus only, no checking).
  task automatic drive(input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic [4:0] a3e, input logic we, input logic [1:0] tne,
                       input logic [4:0] a3m, input logic wm, input logic [1:0] tnm,
                       input logic use_md, input logic st, input logic dv);
    rs_D = rs; Tuse_rs_D = tur; rt_D = rt; Tuse_rt_D = tut;
    A3_E = a3e; RegWrite_E = we; Tnew_E = tne;
    A3_M = a3m; RegWrite_M = wm; Tnew_M = tnm;
    md_use_D = use_md; md_start_E = st; md_div_E = dv;
  endtask

  task automatic idle_inputs();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [3:0] act, exp;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      // Inputs that would stall on every path; reset must override them.
      drive(5'd1, 2'd0, 5'd2, 2'd0, 5'd1, 1'b1, 2'd2, 5'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
      exp_q.push_back(4'b1100);
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL reset cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_data_hazard();
    logic [3:0] act, exp;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      case (i)
        // lw $1 in E, addu reads $1 in D with Tuse=1: one stall
        0: begin drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b0010); end
        // lw now in M (Tnew=1), bubble in E: Tnew==Tuse, no stall
        1: begin drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
        // M producer against Tuse=0 on rs: stall
        2: begin drive(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b0010); end
        // rt path against E with Tnew=1 > Tuse=0: stall
        3: begin drive(5'd0, 2'd3, 5'd5, 2'd0, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b0010); end
        // rt Tnew_E=1 == Tuse=1: no stall
        4: begin drive(5'd0, 2'd3, 5'd5, 2'd1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
        // matching reg but RegWrite_E low: no stall
        default: begin drive(5'd9, 2'd0, 5'd0, 2'd3, 5'd9, 1'b0, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
      endcase
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL data_hazard cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
  endtask

  task automatic test_zero_and_unused();
    logic [3:0] act, exp;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (i)
        // $0 in D and E: never a hazard
        0: begin drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd2, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
        // operand unused (Tuse=3) with matching E producer: no stall
        1: begin drive(5'd3, 2'd3, 5'd3, 2'd3, 5'd3, 1'b1, 2'd2, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
        // same reg in E and M: E condition false, M condition true -> stall
        2: begin drive(5'd4, 2'd0, 5'd0, 2'd3, 5'd4, 1'b1, 2'd0, 5'd4, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b0010); end
        // Tuse=2 vs Tnew_E=2: not greater, no stall
        default: begin drive(5'd6, 2'd2, 5'd0, 2'd3, 5'd6, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
      endcase
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL zero_unused cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
  endtask

  // mult in E with mflo right behind: 6 stall cycles, busy for 5.
  task automatic test_mult_stall();
    logic [3:0] act, exp;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0,
            1'b1, (i == 0), 1'b0);
      if (i == 0)      exp_q.push_back(4'b0010);
      else if (i <= 5) exp_q.push_back(4'b0011);
      else             exp_q.push_back(4'b1100);
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL mult_stall cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
    idle_inputs();
  endtask

  // div with no HI/LO user: busy for 10 cycles, fetch never frozen.
  task automatic test_div_no_user();
    logic [3:0] act, exp;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0,
            1'b0, (i == 0), 1'b1);
      if (i >= 1 && i <= 10) exp_q.push_back(4'b1101);
      else                   exp_q.push_back(4'b1100);
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL div_no_user cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
  endtask

  // Reset in busy cycle 3 of a div aborts the count immediately.
  task automatic test_reset_mid_busy();
    logic [3:0] act, exp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      reset = (i == 3);
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0,
            (i >= 3), (i == 0), 1'b1);
      if (i == 0)      exp_q.push_back(4'b1100);
      else if (i <= 3) exp_q.push_back(4'b1101);  // reset cycle: no stall
      else             exp_q.push_back(4'b1100);  // busy gone, mflo proceeds
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL reset_mid_busy cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  // Data-hazard scenario then mult/mflo scenario, back to back from reset.
  task automatic test_back_to_back();
    logic [3:0] act, exp;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] exp_cnt;
    exp_cnt = 32'd0;
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b0010); end
        1: begin drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'b1100); end
        2: begin drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0); exp_q.push_back(4'b0010); end
        8: begin idle_inputs(); exp_q.push_back(4'b1100); end
        default: begin drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); exp_q.push_back(4'b0011); end
      endcase
      @(negedge clk);
      act = {IF_en, D_en, E_clr, md_busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) $display("FAIL back_to_back cyc%0d: got %b want %b", i, act, exp);
      else n_pass++;
`ifdef HAZARD_STALL_CNT_EN
      // Counter reflects stalls from earlier cycles only.
      n_checks++;
      if (stall_cycles !== exp_cnt) $display("FAIL stall_cycles cyc%0d: got %0d want %0d", i, stall_cycles, exp_cnt);
      else n_pass++;
      if (exp[1]) exp_cnt = exp_cnt + 32'd1;
`endif
      @(posedge clk); #1;
    end
`ifdef HAZARD_STALL_CNT_EN
    n_checks++;
    if (stall_cycles !== 32'd7) $display("FAIL stall_cycles_total: got %0d want 7", stall_cycles);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 32'd0) $display("FAIL stall_cycles_reset: got %0d want 0", stall_cycles);
    else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_data_hazard();
    test_zero_and_unused();
    test_mult_stall();
    test_div_no_user();
    test_reset_mid_busy();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
